// File: rtl/mult_acc_v3.sv
// Three-stage signed multiply-add/accumulate with per-sample mode, valid tracking
// and optional saturation of the PW-bit result register.
module mult_acc_v3 #(
  parameter int unsigned AW  = 16,
  parameter int unsigned BW  = 16,
  parameter int unsigned CW  = 32,
  parameter int unsigned PW  = 48,
  parameter int unsigned SAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 vin,
  input  logic [1:0]           mode,
  input  logic signed [AW-1:0] ain,
  input  logic signed [BW-1:0] bin,
  input  logic signed [CW-1:0] cin,
  output logic signed [PW-1:0] pout,
  output logic                 vout,
  output logic                 ovf
);

  localparam int unsigned MW = AW + BW;
  localparam int unsigned SW = PW + 1;

  localparam logic [1:0] MODE_ADD  = 2'd0;
  localparam logic [1:0] MODE_SUB  = 2'd1;
  localparam logic [1:0] MODE_ACC  = 2'd2;
  localparam logic [1:0] MODE_DACC = 2'd3;

  if ((PW < MW) || (PW < CW)) begin : g_param_check
    $error("mult_acc_v3: PW must be >= AW+BW and >= CW");
  end

  // Stage 1: input capture
  logic signed [AW-1:0] a1_q;
  logic signed [BW-1:0] b1_q;
  logic signed [CW-1:0] c1_q;
  logic [1:0]           mode1_q;
  logic                 v1_q;

  // Stage 2: product plus delayed addend/mode/valid
  logic signed [MW-1:0] m2_q, m2_d;
  logic signed [CW-1:0] c2_q;
  logic [1:0]           mode2_q;
  logic                 v2_q;

  // Stage 3: result register
  logic signed [PW-1:0] pout_q, pout_d;
  logic                 vout_q, vout_d;
  logic                 ovf_q, ovf_d;

  logic signed [SW-1:0] m_ext, c_ext, p_ext, sum;
  logic                 sum_ovf;
  logic signed [PW-1:0] sum_clamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q    <= '0;
      b1_q    <= '0;
      c1_q    <= '0;
      mode1_q <= '0;
      v1_q    <= 1'b0;
    end else if (ce) begin
      a1_q    <= ain;
      b1_q    <= bin;
      c1_q    <= cin;
      mode1_q <= mode;
      v1_q    <= vin;
    end
  end

  always_comb begin
    m2_d = MW'(a1_q) * MW'(b1_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m2_q    <= '0;
      c2_q    <= '0;
      mode2_q <= '0;
      v2_q    <= 1'b0;
    end else if (ce) begin
      m2_q    <= m2_d;
      c2_q    <= c1_q;
      mode2_q <= mode1_q;
      v2_q    <= v1_q;
    end
  end

  // One guard bit makes the sum exact; overflow is a disagreement of the top two bits.
  always_comb begin
    m_ext = SW'(m2_q);
    c_ext = SW'(c2_q);
    p_ext = SW'(pout_q);
    sum   = '0;
    unique case (mode2_q)
      MODE_ADD:  sum = m_ext + c_ext;
      MODE_SUB:  sum = m_ext - c_ext;
      MODE_ACC:  sum = p_ext + m_ext;
      MODE_DACC: sum = p_ext - m_ext;
      default:   sum = '0;
    endcase
    sum_ovf   = sum[PW] ^ sum[PW-1];
    sum_clamp = sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
  end

  // Invalid samples only drop vout; pout/ovf are held so the accumulator survives bubbles.
  always_comb begin
    pout_d = pout_q;
    ovf_d  = ovf_q;
    vout_d = v2_q;
    if (v2_q) begin
      pout_d = ((SAT != 0) && sum_ovf) ? sum_clamp : sum[PW-1:0];
      ovf_d  = sum_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pout_q <= '0;
      vout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ce) begin
      pout_q <= pout_d;
      vout_q <= vout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pout = pout_q;
  assign vout = vout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/mult_acc_v3.md
Name: mult_acc_v3

Overview:
- Parametrised signed multiply-add/accumulate unit; next generation of the two-stage multiply-add.
- Adds per-sample mode select (add, subtract, accumulate, de-accumulate), valid tracking, and optional saturation with an overflow flag.
- Sits in DSP datapaths (filters, correlators) feeding result registers or downstream FIFOs.

Parameters:
- AW, 16, signed width of ain.
- BW, 16, signed width of bin.
- CW, 32, signed width of cin.
- PW, 48, signed width of pout; legal only if PW >= AW+BW and PW >= CW (elaboration error otherwise).
- SAT, 0, 1 = clamp result to PW range; 0 = two's-complement wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  pipeline enable; 0 freezes every stage.
- vin  in  1  input sample valid.
- mode  in  2  0: a*b+c; 1: a*b-c; 2: pout+a*b; 3: pout-a*b.
- ain  in  AW  signed multiplicand.
- bin  in  BW  signed multiplier.
- cin  in  CW  signed addend, used in modes 0/1 only.
- pout  out  PW  signed result register.
- vout  out  1  pout updated by a valid sample on the last ce edge.
- ovf  out  1  overflow of the result written with the current pout.

Behaviour:
- Reset, asynchronous on rst_n low: all pipeline registers, pout, vout and ovf go to 0. Release is synchronous to clk and takes effect on the next edge.
- Reset mid-operation discards all in-flight samples and clears the accumulator.
- Pipeline: three stages; every register updates only on a rising edge with ce=1.
  - S1 registers ain, bin, cin, mode, vin.
  - S2 registers m = a*b (AW+BW bits, signed) together with the delayed c, mode and valid.
  - S3 computes the result into pout.
- Latency: a sample presented with vin=1 on ce edge k appears on pout with vout=1 after ce edge k+2, i.e. three ce edges including capture.
- ce=0 cycles do not count. pout, vout and ovf hold their values while ce=0.
- S3 update, on a ce edge:
  - If S2 valid=0: pout and ovf hold; vout <= 0.
  - If S2 valid=1: vout <= 1, and pout/ovf are loaded per mode.
  - Invalid samples never disturb the accumulator.
- Arithmetic:
  - m and c are sign-extended to PW+1 bits; pout is sign-extended to PW+1 bits as the feedback operand.
  - Sum s = m + c, m - c, pout + m, or pout - m according to the S2 mode.
  - Overflow: s outside [-2^(PW-1), 2^(PW-1)-1].
  - SAT=1: pout <= clamp(s); ovf <= overflow.
  - SAT=0: pout <= s[PW-1:0]; ovf <= overflow (flag only).
- Accumulator semantics:
  - Modes 0/1 start a new accumulation, since pout is overwritten.
  - Modes 2/3 use the pout value current at the S3 edge. Back-to-back accumulate samples therefore chain correctly with no bubbles.
- Mixed modes in consecutive samples are legal. Each sample uses its own mode as carried through the pipe.
- ovf is not sticky: it reflects only the latest valid write.
- No backpressure: ce is the only flow control.

Test Plan:
- Reset, then ain=3, bin=-4, cin=5, mode=0, vin=1 for one ce edge -> after 3 ce edges pout=-7, vout=1, ovf=0; next edge with vin=0 -> vout=0, pout holds -7.
- Same operands with mode=1 -> pout=-17. Then four back-to-back mode=2 samples with a=2, b=3 -> pout steps -11, -5, 1, 7 on consecutive edges with vout=1 throughout.
- ce stall: inject mode=0, a=5, b=5, c=0, hold ce=0 for 4 cycles mid-pipe -> pout=25 appears exactly 3 ce-high edges after capture; outputs frozen during the stall.
- Saturation, PW=32, SAT=1: a=-32768, b=-32768, c=2147483647, mode=0 -> pout=2147483647, ovf=1. The same test with SAT=0 -> pout=-1073741825 (wrapped), ovf=1.
- Reset mid-operation: rst_n low for half a cycle with 2 valid samples in flight -> pout=0, vout=0 and ovf=0 immediately (asynchronously). No stale vout after release; a following mode=2 sample with a=1, b=1 gives pout=1.
- Randomised vs model: ain/bin in [-10,10], cin in [-20,20], random mode/vin/ce for 1000 cycles -> pout, vout and ovf match the reference model every cycle.
